// File: rtl/reverse_double_dabble_if.sv
// rtl/reverse_double_dabble_if.sv - request/result bundle for the BCD-to-binary converter
interface reverse_double_dabble_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic [4*DIGITS-1:0] i_BCD;
    logic                start;
    logic [BIN_W-1:0]    o_Binary;
    logic                o_DV;
    logic                o_busy;
    logic                o_err;

    modport master (
        output i_BCD, start,
        input  o_Binary, o_DV, o_busy, o_err
    );

    modport slave (
        input  i_BCD, start,
        output o_Binary, o_DV, o_busy, o_err
    );
endinterface

// File: rtl/reverse_double_dabble.sv
// rtl/reverse_double_dabble.sv - sequential packed-BCD to binary converter (reverse double dabble)
module reverse_double_dabble #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    reverse_double_dabble_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ADJUST, DONE} state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd;
    logic [BIN_W-1:0]   bin;
    logic [CNT_W-1:0]   count;
    logic               err_lat;

    function automatic logic has_invalid(input logic [BCD_W-1:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r = 1'b1;
        end
        return r;
    endfunction

    // A digit >= 8 after the shift carries the halved 10 from the digit above; -3 turns +8 into +5.
    function automatic logic [BCD_W-1:0] adjust_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd8) r[4*i +: 4] = v[4*i +: 4] - 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bcd          <= '0;
            bin          <= '0;
            count        <= '0;
            err_lat      <= 1'b0;
            bus.o_Binary <= '0;
            bus.o_DV     <= 1'b0;
            bus.o_busy   <= 1'b0;
            bus.o_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.o_DV <= 1'b0;
                    if (bus.start) begin
                        bcd        <= bus.i_BCD;
                        bin        <= '0;
                        count      <= '0;
                        err_lat    <= has_invalid(bus.i_BCD);
                        bus.o_err  <= 1'b0;
                        bus.o_busy <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {1'b0, bcd, bin[BIN_W-1:1]};
                    count      <= count + CNT_W'(1);
                    state      <= ADJUST;
                end
                ADJUST: begin
                    bcd   <= adjust_digits(bcd);
                    state <= (count == CNT_W'(BIN_W)) ? DONE : SHIFT;
                end
                DONE: begin
                    bus.o_Binary <= err_lat ? '0 : bin;
                    bus.o_err    <= err_lat;
                    bus.o_DV     <= 1'b1;
                    bus.o_busy   <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // With a wide enough BIN_W every decimal weight has been drained into bin.
    a_bcd_drained: assert property (@(posedge clk) disable iff (rst)
        (state == DONE && !err_lat) |-> (bcd == '0));

endmodule

// File: tb/tb_reverse_double_dabble.sv
// tb/tb_reverse_double_dabble.sv - scoreboard bench for reverse_double_dabble
module tb_reverse_double_dabble;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int LAT    = 2 * BIN_W + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        int               at;
    } exp_t;
    exp_t sb[$];

    reverse_double_dabble_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    reverse_double_dabble #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: every o_DV pops one expectation and checks value, error flag and arrival cycle.
    always @(negedge clk) begin
        if (bus.o_DV) begin
            if (sb.size() == 0) begin
                check("unexpected_dv", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("o_Binary", int'(bus.o_Binary), int'(e.bin));
                check("o_err", int'(bus.o_err), int'(e.err));
                check("dv_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100 && bus.o_busy; i++) @(negedge clk);
        if (bus.o_busy) check("idle_timeout", 1, 0);
    endtask

    task automatic convert(input logic [11:0] bcd, input logic [BIN_W-1:0] exp_bin,
                           input logic exp_err);
        exp_t e;
        wait_idle();
        bus.i_BCD = bcd;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        e.bin = exp_bin;
        e.err = exp_err;
        e.at  = cyc + LAT;
        sb.push_back(e);
    endtask

    logic [11:0]      vec_bcd [8] = '{12'h000, 12'h999, 12'h255, 12'h001,
                                      12'h100, 12'h909, 12'h010, 12'h1A3};
    logic [BIN_W-1:0] vec_bin [8] = '{10'd0, 10'h3E7, 10'h0FF, 10'd1,
                                      10'd100, 10'd909, 10'd10, 10'd0};
    logic             vec_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        exp_t e;
        int i;
        bus.i_BCD = '0;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({bus.o_Binary, bus.o_DV, bus.o_busy, bus.o_err}), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 8; k++) convert(vec_bcd[k], vec_bin[k], vec_err[k]);
        check("busy_while_converting", int'(bus.o_busy), 1);

        convert(12'h042, 10'd42, 1'b0);
        check("err_cleared_on_start", int'(bus.o_err), 0);

        // start held high: back-to-back accepts every 2*BIN_W+2 cycles; input changes mid-run ignored
        wait_idle();
        bus.i_BCD = 12'h128;
        bus.start = 1'b1;
        @(negedge clk);
        e.bin = 10'd128; e.err = 1'b0; e.at = cyc + LAT;
        sb.push_back(e);
        repeat (LAT + 1) @(negedge clk);
        e.at = cyc + LAT;
        sb.push_back(e);
        repeat (5) @(negedge clk);
        bus.i_BCD = 12'h777;
        bus.start = 1'b0;

        // reset in the middle of a conversion aborts it with no o_DV
        wait_idle();
        @(negedge clk);
        bus.i_BCD = 12'h500;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", int'({bus.o_Binary, bus.o_DV, bus.o_busy, bus.o_err}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        convert(12'h500, 10'd500, 1'b0);

        for (i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (30) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
